ifid_skid_stage: RTL
====================

IFID_SKID_STAGE -- requirements
Module: ifid_skid_stage

Interface
REQ-001 Parameter PC_W, default 32, width of the PC+4 path.
REQ-002 Parameter NOP_INS, default 32'h0000_0000, instruction presented whenever the stage holds no valid entry.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 Port clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  fetch side presents an instruction.
REQ-007 Port in_ready  output  1  stage can accept; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-008 Port in_pcp4  input  PC_W  PC+4 of the fetched instruction.
REQ-009 Port in_ins  input  32  fetched instruction word.
REQ-010 Port flush  input  1  synchronous discard of all held and incoming entries (branch/jump redirect).
REQ-011 Port out_valid  output  1  decode side sees a valid entry.
REQ-012 Port out_ready  input  1  decode side consumes; pop occurs when out_valid and out_ready are both high.
REQ-013 Port out_pcp4  output  PC_W  PC+4 of the head entry.
REQ-014 Port out_ins  output  32  head instruction word.
REQ-015 Ports op[5:0]=ins[31:26], rs_fmt[4:0]=ins[25:21], rt_ft[4:0]=ins[20:16], rd_fs[4:0]=ins[15:11], sh_fd[4:0]=ins[10:6], fun[5:0]=ins[5:0], im[15:0]=ins[15:0], ad[25:0]=ins[25:0]; all outputs, all sliced from out_ins.
REQ-016 Port occupancy  output  2  number of held entries (0..2).
REQ-017 Port stall_cycles  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 Storage is two entries, head and skid, each holding {pcp4, ins}; state is one of EMPTY (0), HALF (1), FULL (2); occupancy equals the state encoding.
REQ-019 in_ready is high in EMPTY and HALF, low in FULL, and depends only on registered state (no combinational path from out_ready).
REQ-020 EMPTY transitions: accept -> HALF with head loaded from the input.
REQ-021 HALF transitions: accept only -> FULL with skid loaded; pop only -> EMPTY; accept and pop -> HALF with head loaded from the input.
REQ-022 FULL transitions: pop -> HALF with head loaded from skid; no pop -> stay.
REQ-023 Order is strictly FIFO; no entry is duplicated or dropped except by flush.
REQ-024 Latency is 1 cycle: an entry accepted at edge N is visible with out_valid high after edge N.
REQ-025 Throughput is one entry per cycle when out_ready is held high.
REQ-026 out_valid is high exactly when state is not EMPTY.
REQ-027 In EMPTY: out_ins = NOP_INS, out_pcp4 = 0, and all field outputs decode NOP_INS.
REQ-028 flush has the highest priority: the next state is EMPTY, both entries are discarded, and any input transfer in the same cycle counts as accepted and is dropped.
REQ-029 A pop in the flush cycle is legal; the entry is consumed as presented and no later entry appears.
REQ-030 stall_cycles increments by 1 in each cycle with out_valid high and out_ready low, holds at 2^CNT_W-1, and is cleared by flush.

Reset
REQ-031 Asserting rst_n low immediately forces EMPTY, in_ready=1, out_valid=0, out_ins=NOP_INS, out_pcp4=0, occupancy=0, stall_cycles=0, independent of clk.
REQ-032 Reset asserted mid-operation discards all held entries; the first accept after release behaves as from EMPTY.

Structure
REQ-033 The shared pipeline package holds the field-slice positions, the state enumeration (EMPTY/HALF/FULL), and the default NOP constant.
REQ-034 The field decode is a combinational sub-module, ins_fields, that this stage and other stages reuse.

Verification
REQ-035 Streaming with out_ready=1: push pcp4 4,8,12 with ins 0x2108_0001, 0x0000_0020, 0x0800_0010 -> out_valid from cycle 1, same order, op=0x08/0x00/0x02, occupancy stays 1.
REQ-036 Back-pressure: hold out_ready=0 and push A, B, C -> A and B held, in_ready=0 after B, C waits; stall_cycles counts; raise out_ready -> A, B, C delivered in order, none lost.
REQ-037 Flush in FULL with a concurrent push -> next cycle occupancy=0, out_valid=0, out_ins=0, stall_cycles=0; the pushed entry never appears.
REQ-038 Simultaneous push and pop in HALF -> occupancy remains 1 and the head updates to the new entry.
REQ-039 rst_n asserted between edges while FULL -> outputs reach reset values before the next edge; the post-release push of pcp4=0x40 appears alone.
REQ-040 CNT_W=2 with out_ready low for 6 cycles -> stall_cycles saturates at 3.

Source files
------------

// File: rtl/ifid_skid_stage_pkg.sv
// Shared pipeline definitions: instruction field positions, skid state encoding
// and the default bubble instruction.
package ifid_skid_stage_pkg;

  localparam int unsigned INS_W   = 32;

  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned FUN_LSB = 0;
  localparam int unsigned IM_LSB  = 0;
  localparam int unsigned AD_LSB  = 0;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUN_W   = 6;
  localparam int unsigned IM_W    = 16;
  localparam int unsigned AD_W    = 26;

  localparam logic [INS_W-1:0] NOP_INS_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ifid_skid_stage_ins_fields.sv
// Combinational instruction field decode, shared by the pipeline stages.
module ins_fields
  import ifid_skid_stage_pkg::*;
(
  input  logic [INS_W-1:0] ins,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] rs_fmt,
  output logic [REG_W-1:0] rt_ft,
  output logic [REG_W-1:0] rd_fs,
  output logic [REG_W-1:0] sh_fd,
  output logic [FUN_W-1:0] fun,
  output logic [IM_W-1:0]  im,
  output logic [AD_W-1:0]  ad
);

  assign op     = ins[OP_LSB  +: OP_W];
  assign rs_fmt = ins[RS_LSB  +: REG_W];
  assign rt_ft  = ins[RT_LSB  +: REG_W];
  assign rd_fs  = ins[RD_LSB  +: REG_W];
  assign sh_fd  = ins[SH_LSB  +: REG_W];
  assign fun    = ins[FUN_LSB +: FUN_W];
  assign im     = ins[IM_LSB  +: IM_W];
  assign ad     = ins[AD_LSB  +: AD_W];

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so in_ready depends only
// on registered state; the head register doubles as the output register.
module ifid_skid_stage
  import ifid_skid_stage_pkg::*;
#(
  parameter int unsigned       PC_W    = 32,
  parameter logic [INS_W-1:0]  NOP_INS = NOP_INS_DEFAULT,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pcp4,
  input  logic [INS_W-1:0]  in_ins,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pcp4,
  output logic [INS_W-1:0]  out_ins,
  output logic [OP_W-1:0]   op,
  output logic [REG_W-1:0]  rs_fmt,
  output logic [REG_W-1:0]  rt_ft,
  output logic [REG_W-1:0]  rd_fs,
  output logic [REG_W-1:0]  sh_fd,
  output logic [FUN_W-1:0]  fun,
  output logic [IM_W-1:0]   im,
  output logic [AD_W-1:0]   ad,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  skid_state_e       state_q, state_d;
  logic [PC_W-1:0]   head_pcp4_q, head_pcp4_d;
  logic [INS_W-1:0]  head_ins_q,  head_ins_d;
  logic [PC_W-1:0]   skid_pcp4_q, skid_pcp4_d;
  logic [INS_W-1:0]  skid_ins_q,  skid_ins_d;
  logic [CNT_W-1:0]  stall_q,     stall_d;
  logic              push;
  logic              pop;

  assign in_ready     = (state_q != FULL);
  assign out_valid    = (state_q != EMPTY);
  assign occupancy    = state_q;
  assign out_pcp4     = head_pcp4_q;
  assign out_ins      = head_ins_q;
  assign stall_cycles = stall_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State and storage registers; an empty head holds the bubble so outputs need no mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_pcp4_q <= '0;
      head_ins_q  <= NOP_INS;
      skid_pcp4_q <= '0;
      skid_ins_q  <= NOP_INS;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_pcp4_q <= head_pcp4_d;
      head_ins_q  <= head_ins_d;
      skid_pcp4_q <= skid_pcp4_d;
      skid_ins_q  <= skid_ins_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state: flush dominates, otherwise the EMPTY/HALF/FULL transfer table.
  always_comb begin
    state_d     = state_q;
    head_pcp4_d = head_pcp4_q;
    head_ins_d  = head_ins_q;
    skid_pcp4_d = skid_pcp4_q;
    skid_ins_d  = skid_ins_q;
    stall_d     = stall_q;

    if (flush) begin
      state_d     = EMPTY;
      head_pcp4_d = '0;
      head_ins_d  = NOP_INS;
      stall_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = HALF;
            head_pcp4_d = in_pcp4;
            head_ins_d  = in_ins;
          end
        end
        HALF: begin
          if (push && pop) begin
            head_pcp4_d = in_pcp4;
            head_ins_d  = in_ins;
          end else if (push) begin
            state_d     = FULL;
            skid_pcp4_d = in_pcp4;
            skid_ins_d  = in_ins;
          end else if (pop) begin
            state_d     = EMPTY;
            head_pcp4_d = '0;
            head_ins_d  = NOP_INS;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = HALF;
            head_pcp4_d = skid_pcp4_q;
            head_ins_d  = skid_ins_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          head_pcp4_d = '0;
          head_ins_d  = NOP_INS;
        end
      endcase

      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end
    end
  end

  ins_fields u_fields (
    .ins    (head_ins_q),
    .op     (op),
    .rs_fmt (rs_fmt),
    .rt_ft  (rt_ft),
    .rd_fs  (rd_fs),
    .sh_fd  (sh_fd),
    .fun    (fun),
    .im     (im),
    .ad     (ad)
  );

endmodule
